// File: rtl/present_pkg.sv
// Shared constants, S-box table and FSM encoding for the toy 16/20-bit PRESENT datapath.
package present_pkg;

    localparam int KEY_W      = 20;
    localparam int BLK_W      = 16;
    localparam int NUM_ROUNDS = 7;
    localparam int NUM_KEYS   = NUM_ROUNDS + 1;
    localparam int ROT        = 15;

    // Element 0 sits in the rightmost nibble, so PRESENT_SBOX[x] is S(x).
    localparam logic [15:0][3:0] PRESENT_SBOX = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/present_sbox.sv
// Combinational PRESENT 4-bit S-box, shared between key schedule and cipher rounds.
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = PRESENT_SBOX[din];

endmodule

// File: rtl/present_key_expander.sv
// Sequential PRESENT round-key generator: one schedule update per clock after a
// master-key load, round keys held in a register file until the next load.
module present_key_expander
    import present_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [KEY_W-1:0]          master_key,
    output logic                      busy,
    output logic                      keys_valid,
    input  logic [2:0]                rd_idx,
    output logic [BLK_W-1:0]          rd_key,
    output logic [BLK_W*NUM_KEYS-1:0] keys_flat
);

    state_e           state;
    logic [2:0]       cnt;
    logic [KEY_W-1:0] k_reg;
    logic [KEY_W-1:0] k_rot;
    logic [KEY_W-1:0] k_next;
    logic [3:0]       sb_out;
    logic [BLK_W-1:0] key_rf [NUM_KEYS];

    assign k_rot = (k_reg << ROT) | (k_reg >> (KEY_W - ROT));

    present_sbox u_sbox (
        .din  (k_rot[KEY_W-1 -: 4]),
        .dout (sb_out)
    );

    assign k_next = {sb_out, k_rot[KEY_W-5:3], k_rot[2:0] ^ cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            k_reg      <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_rf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_valid) begin
                        k_reg      <= master_key;
                        key_rf[0]  <= master_key[KEY_W-1 -: BLK_W];
                        cnt        <= 3'd1;
                        state      <= RUN;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                    end
                end
                RUN: begin
                    k_reg       <= k_next;
                    key_rf[cnt] <= k_next[KEY_W-1 -: BLK_W];
                    // cnt stops at its final value rather than wrapping to 0.
                    if (cnt == 3'(NUM_ROUNDS)) begin
                        state      <= DONE;
                        load_ready <= 1'b1;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                    keys_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rd_key = key_rf[rd_idx];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_flat
        assign keys_flat[i*BLK_W +: BLK_W] = key_rf[i];
    end

endmodule

// File: tb/tb_present_key_expander.sv
// Self-checking bench for present_key_expander against a key-schedule model.
module tb_present_key_expander;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic         load_ready;
    logic [19:0]  master_key;
    logic         busy;
    logic         keys_valid;
    logic [2:0]   rd_idx;
    logic [15:0]  rd_key;
    logic [127:0] keys_flat;

    int checks   = 0;
    int failures = 0;

    int           sbox_tbl [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [15:0]  exp_keys [8];
    logic [127:0] exp_flat;

    present_key_expander dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .master_key (master_key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .keys_flat  (keys_flat)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] upd_model(input logic [19:0] k, input int r);
        logic [19:0] t;
        t = 20'((40'(k) << 15) | 40'(k >> 5));
        t = (t & 20'h0FFFF) | (20'(sbox_tbl[t >> 16]) << 16);
        t = t ^ 20'(r % 8);
        return t;
    endfunction

    function automatic void build_model(input logic [19:0] mk);
        logic [19:0] k;
        k = mk;
        exp_keys[0] = 16'(mk >> 4);
        for (int r = 1; r < 8; r++) begin
            k = upd_model(k, r);
            exp_keys[r] = 16'(k >> 4);
        end
        exp_flat = '0;
        for (int i = 0; i < 8; i++) begin
            exp_flat = exp_flat | (128'(exp_keys[i]) << (16 * i));
        end
    endfunction

    task automatic check_keys(input logic [19:0] mk, input bit sweep);
        build_model(mk);
        checks++;
        if (keys_flat !== exp_flat) begin
            failures++;
            $display("FAIL keys_flat mk=%h got=%h exp=%h", mk, keys_flat, exp_flat);
        end
        if (sweep) begin
            for (int i = 0; i < 8; i++) begin
                rd_idx = 3'(i);
                #1;
                checks++;
                if (rd_key !== exp_keys[i]) begin
                    failures++;
                    $display("FAIL rd_key idx=%0d got=%h exp=%h", i, rd_key, exp_keys[i]);
                end
            end
        end
    endtask

    // Presents mk for one edge, then follows the schedule into DONE.
    task automatic do_load(input logic [19:0] mk, input bit sweep);
        load_valid = 1'b1;
        master_key = mk;
        tick();
        load_valid = 1'b0;
        master_key = 20'($urandom);
        for (int j = 0; j <= 7; j++) begin
            if (j > 0) tick();
            checks++;
            if (keys_valid !== (j == 7) || busy !== (j != 7)) begin
                failures++;
                $display("FAIL timing cycle=%0d keys_valid=%b busy=%b exp_valid=%b",
                         j, keys_valid, busy, (j == 7));
            end
        end
        check_keys(mk, sweep);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        master_key = '0;
        rd_idx     = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0 || keys_flat !== '0) begin
            failures++;
            $display("FAIL reset_outputs ready=%b busy=%b valid=%b flat=%h exp=1/0/0/0",
                     load_ready, busy, keys_valid, keys_flat);
        end
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            checks++;
            if (rd_key !== 16'h0) begin
                failures++;
                $display("FAIL reset_rd_key idx=%0d got=%h exp=0000", i, rd_key);
            end
        end
    endtask

    task automatic test_zero_key();
        do_load(20'h00000, 1'b1);
        checks++;
        if (keys_flat[15:0] !== 16'h0000 || keys_flat[31:16] !== 16'hC000 ||
            keys_flat[47:32] !== 16'hCE00) begin
            failures++;
            $display("FAIL zero_key_k0k1k2 got=%h %h %h exp=0000 C000 CE00",
                     keys_flat[15:0], keys_flat[31:16], keys_flat[47:32]);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 1000; n++) begin
            do_load(20'($urandom), (n % 100) == 0);
        end
    endtask

    task automatic test_load_during_run();
        logic [19:0] mk0;
        mk0        = 20'($urandom);
        load_valid = 1'b1;
        master_key = mk0;
        tick();
        for (int j = 1; j <= 7; j++) begin
            checks++;
            if (load_ready !== 1'b0) begin
                failures++;
                $display("FAIL run_load_ready cycle=%0d got=%b exp=0", j, load_ready);
            end
            master_key = 20'($urandom);
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if (keys_valid !== 1'b1) begin
            failures++;
            $display("FAIL run_ignore_done got=%b exp=1", keys_valid);
        end
        check_keys(mk0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        load_valid = 1'b1;
        master_key = 20'($urandom);
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (load_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0 || keys_flat !== '0) begin
            failures++;
            $display("FAIL async_reset ready=%b busy=%b valid=%b flat=%h exp=1/0/0/0",
                     load_ready, busy, keys_valid, keys_flat);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_load(20'($urandom), 1'b1);
    endtask

    task automatic test_done_hold();
        logic [19:0]  mk;
        logic [127:0] saved;
        mk = 20'($urandom);
        do_load(mk, 1'b0);
        saved = keys_flat;
        for (int c = 0; c < 100; c++) begin
            rd_idx     = 3'(c % 8);
            load_valid = 1'b0;
            master_key = 20'($urandom);
            tick();
            checks++;
            if (keys_valid !== 1'b1 || keys_flat !== saved || rd_key !== exp_keys[c % 8] ||
                rd_key !== keys_flat[16*(c%8) +: 16]) begin
                failures++;
                $display("FAIL done_hold cycle=%0d valid=%b rd_key=%h exp=%h flat=%h exp_flat=%h",
                         c, keys_valid, rd_key, exp_keys[c % 8], keys_flat, saved);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_back_to_back();
        test_load_during_run();
        test_reset_mid_run();
        test_done_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
